// File: rtl/framer_pkg.sv
// Shared types, constants and header-beat builder for the packet framer.
package framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_HDR,
        ST_SEQ,
        ST_PAY,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [31:0] HEAD_DEFAULT = 32'hADF90C00;

    typedef struct packed {
        logic [31:0] sync;
        logic [31:0] ch;
    } hdr_t;

    function automatic hdr_t build_header(input logic [31:0] head, input logic [31:0] ch);
        hdr_t h;
        h.sync = head;
        h.ch   = ch;
        return h;
    endfunction

endpackage

// File: rtl/pkt_framer_if.sv
// FIFO-side and uplink-side signal bundle of the packet framer.
interface pkt_framer_if #(
    parameter int unsigned DW   = 64,
    parameter int unsigned CH_W = 5,
    parameter int unsigned UW   = 12
);
    logic            start;
    logic [CH_W-1:0] ch_id;
    logic [UW-1:0]   rdusedw;
    logic [DW-1:0]   fifo_out;
    logic            rdreq;
    logic            out_ready;
    logic            data_valid;
    logic [DW-1:0]   up_data;
    logic            sop;
    logic            eop;
    logic            over;
    logic            skipped;
    logic            ch_err;

    modport master (
        input  start, ch_id, rdusedw, fifo_out, out_ready,
        output rdreq, data_valid, up_data, sop, eop, over, skipped, ch_err
    );

    modport slave (
        output start, ch_id, rdusedw, fifo_out, out_ready,
        input  rdreq, data_valid, up_data, sop, eop, over, skipped, ch_err
    );
endinterface

// File: rtl/seq_cnt_bank.sv
// Per-channel packet sequence counters; exposes the incremented value of the indexed channel.
module seq_cnt_bank #(
    parameter int unsigned CH_NUM = 30,
    parameter int unsigned CH_W   = 5,
    parameter int unsigned SEQ_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [CH_W-1:0]  idx,
    output logic [SEQ_W-1:0] nxt
);
    logic [SEQ_W-1:0] cnt [CH_NUM];
    logic             in_range;

    // Out-of-range indices read as zero and never write.
    assign in_range = 32'(idx) < CH_NUM;
    assign nxt      = in_range ? cnt[idx] + SEQ_W'(1) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                cnt[i] <= '0;
            end
        end else if (inc && in_range) begin
            cnt[idx] <= nxt;
        end
    end
endmodule

// File: rtl/pkt_framer.sv
// Checks the selected channel FIFO level and frames header, sequence and payload beats
// onto a valid/ready uplink stream with a single-stage output register.
module pkt_framer
    import framer_pkg::*;
#(
    parameter int unsigned DW      = 64,
    parameter int unsigned PKT_LEN = 128,
    parameter int unsigned CH_NUM  = 30,
    parameter int unsigned CH_W    = 5,
    parameter int unsigned UW      = 12,
    parameter logic [31:0] HEAD    = HEAD_DEFAULT,
    parameter int unsigned SEQ_W   = 32
) (
    input  logic         clk,
    input  logic         rst,
    pkt_framer_if.master bus
);
    localparam int unsigned BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    state_t           state;
    logic [CH_W-1:0]  ch_q;
    logic [BW-1:0]    beat;
    logic [SEQ_W-1:0] seq_val;
    logic [SEQ_W-1:0] seq_nxt;
    logic             skip_f;
    logic             err_f;

    logic             valid_q;
    logic [DW-1:0]    data_q;
    logic             sop_q;
    logic             eop_q;
    logic             over_q;
    logic             skip_q;
    logic             err_q;

    logic             adv;
    logic             seq_inc;
    logic             last_beat;
    logic             ch_bad;
    logic             enough;

    // Output register may load whenever it is empty or being drained this cycle.
    assign adv       = ~valid_q | bus.out_ready;
    assign seq_inc   = (state == ST_HDR) && adv;
    assign last_beat = (beat == BW'(PKT_LEN - 1));
    assign ch_bad    = 32'(ch_q) >= CH_NUM;
    assign enough    = 32'(bus.rdusedw) >= PKT_LEN;

    assign bus.rdreq      = (state == ST_PAY) && adv;
    assign bus.data_valid = valid_q;
    assign bus.up_data    = data_q;
    assign bus.sop        = sop_q;
    assign bus.eop        = eop_q;
    assign bus.over       = over_q;
    assign bus.skipped    = skip_q;
    assign bus.ch_err     = err_q;

    seq_cnt_bank #(
        .CH_NUM (CH_NUM),
        .CH_W   (CH_W),
        .SEQ_W  (SEQ_W)
    ) u_seq (
        .clk (clk),
        .rst (rst),
        .inc (seq_inc),
        .idx (ch_q),
        .nxt (seq_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ch_q    <= '0;
            beat    <= '0;
            seq_val <= '0;
            skip_f  <= 1'b0;
            err_f   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            over_q  <= 1'b0;
            skip_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            over_q <= 1'b0;
            skip_q <= 1'b0;
            err_q  <= 1'b0;
            if (adv) begin
                valid_q <= 1'b0;
                sop_q   <= 1'b0;
                eop_q   <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        ch_q  <= bus.ch_id;
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    err_f  <= ch_bad;
                    skip_f <= ~ch_bad & ~enough;
                    state  <= (~ch_bad & enough) ? ST_HDR : ST_DONE;
                end
                ST_HDR: begin
                    if (adv) begin
                        valid_q <= 1'b1;
                        sop_q   <= 1'b1;
                        data_q  <= DW'(build_header(HEAD, 32'(ch_q)));
                        seq_val <= seq_nxt;
                        state   <= ST_SEQ;
                    end
                end
                ST_SEQ: begin
                    if (adv) begin
                        valid_q <= 1'b1;
                        data_q  <= DW'(seq_val);
                        beat    <= '0;
                        state   <= ST_PAY;
                    end
                end
                ST_PAY: begin
                    if (adv) begin
                        valid_q <= 1'b1;
                        data_q  <= bus.fifo_out;
                        beat    <= beat + BW'(1);
                        if (last_beat) begin
                            eop_q <= 1'b1;
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (adv) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    over_q <= 1'b1;
                    skip_q <= skip_f;
                    err_q  <= err_f;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_framer.sv
// Directed scenario bench for pkt_framer with PKT_LEN=4, CH_NUM=30.
module tb_pkt_framer;
    localparam int unsigned DW      = 64;
    localparam int unsigned PKT_LEN = 4;
    localparam int unsigned CH_NUM  = 30;
    localparam int unsigned CH_W    = 5;
    localparam int unsigned UW      = 12;
    localparam logic [31:0] HEAD    = 32'hADF90C00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pkt_framer_if #(.DW(DW), .CH_W(CH_W), .UW(UW)) bus ();

    pkt_framer #(
        .DW(DW), .PKT_LEN(PKT_LEN), .CH_NUM(CH_NUM), .CH_W(CH_W),
        .UW(UW), .HEAD(HEAD), .SEQ_W(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // FIFO model: head word counts up from 0x10 per pop since the last start.
    int cyc = 0;
    int pop_total = 0;
    int pop_start = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rdreq) pop_total <= pop_total + 1;
    end
    assign bus.fifo_out = 64'h10 + 64'(pop_total - pop_start);

    // Mid-cycle monitor recording accepted beats, over pulses and protocol counters.
    logic [65:0] beat_mem [256];
    int          beat_cyc [256];
    int          beat_n = 0;
    logic [1:0]  over_flg [64];
    int          over_cyc [64];
    int          over_n = 0;
    int          rdreq_cnt = 0;
    int          valid_cnt = 0;
    int          stall_bad = 0;
    int          rdreq_bad = 0;
    logic        prev_stall = 1'b0;
    logic [65:0] prev_beat = '0;

    always @(negedge clk) begin
        if (bus.data_valid && bus.out_ready && beat_n < 256) begin
            beat_mem[beat_n] <= {bus.sop, bus.eop, bus.up_data};
            beat_cyc[beat_n] <= cyc;
            beat_n           <= beat_n + 1;
        end
        if (bus.over && over_n < 64) begin
            over_flg[over_n] <= {bus.skipped, bus.ch_err};
            over_cyc[over_n] <= cyc;
            over_n           <= over_n + 1;
        end
        if (bus.rdreq) rdreq_cnt <= rdreq_cnt + 1;
        if (bus.data_valid) valid_cnt <= valid_cnt + 1;
        if (bus.rdreq && bus.data_valid && !bus.out_ready) rdreq_bad <= rdreq_bad + 1;
        if (prev_stall && !rst &&
            (!bus.data_valid || {bus.sop, bus.eop, bus.up_data} != prev_beat))
            stall_bad <= stall_bad + 1;
        prev_stall <= bus.data_valid && !bus.out_ready && !rst;
        prev_beat  <= {bus.sop, bus.eop, bus.up_data};
    end

    function automatic logic [65:0] exp_beat(input int k, input int ch, input int seq);
        if (k == 0) return {2'b10, HEAD, 32'(ch)};
        if (k == 1) return {2'b00, 64'(seq)};
        return {1'b0, (k == int'(PKT_LEN) + 1), 64'h10 + 64'(k - 2)};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_start(input int ch, input int used, output int s);
        @(posedge clk); #1;
        bus.ch_id   = CH_W'(ch);
        bus.rdusedw = UW'(used);
        bus.start   = 1'b1;
        pop_start   = pop_total;
        @(posedge clk); #1;
        bus.start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_over(input int budget, input logic [15:0] pat, input int plen,
                             output bit timed_out);
        int base;
        base = over_n;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            bus.out_ready = pat[i % plen];
            @(negedge clk); #1;
            if (over_n != base) begin
                timed_out = 1'b0;
                break;
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.ch_id = '0;
        bus.rdusedw = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({bus.data_valid, bus.sop, bus.eop, bus.over, bus.skipped, bus.ch_err, bus.rdreq} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {bus.data_valid, bus.sop, bus.eop, bus.over, bus.skipped, bus.ch_err, bus.rdreq});
        end
        checks++;
        if (bus.up_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", bus.up_data);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk); #1;
        checks++;
        if ({bus.data_valid, bus.over, bus.rdreq} !== 3'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 000", {bus.data_valid, bus.over, bus.rdreq});
        end
    endtask

    task automatic test_basic();
        int s, b0, o0, r0;
        bit to;
        apply_reset();
        b0 = beat_n; o0 = over_n; r0 = rdreq_cnt;
        do_start(7, 4, s);
        wait_over(40, 16'hFFFF, 16, to);
        checks++;
        if (to) begin errors++; $display("FAIL basic_timeout: got no over want over"); end
        checks++;
        if (beat_n - b0 != 6) begin errors++; $display("FAIL basic_beat_count: got %0d want 6", beat_n - b0); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (beat_mem[b0+k] !== exp_beat(k, 7, 1)) begin
                errors++;
                $display("FAIL basic_beat%0d: got %h want %h", k, beat_mem[b0+k], exp_beat(k, 7, 1));
            end
            checks++;
            if (beat_cyc[b0+k] != s + 2 + k) begin
                errors++;
                $display("FAIL basic_beat%0d_cycle: got %0d want %0d", k, beat_cyc[b0+k] - s, 2 + k);
            end
        end
        checks++;
        if (rdreq_cnt - r0 != 4) begin errors++; $display("FAIL basic_rdreq_count: got %0d want 4", rdreq_cnt - r0); end
        checks++;
        if (over_n - o0 != 1) begin errors++; $display("FAIL basic_over_count: got %0d want 1", over_n - o0); end
        checks++;
        if (over_flg[o0] !== 2'b00) begin errors++; $display("FAIL basic_over_flags: got %b want 00", over_flg[o0]); end
        checks++;
        if (over_cyc[o0] != s + 9) begin errors++; $display("FAIL basic_over_cycle: got %0d want 9", over_cyc[o0] - s); end
    endtask

    task automatic test_seq_count();
        int s, b0;
        bit to;
        apply_reset();
        for (int p = 1; p <= 3; p++) begin
            b0 = beat_n;
            do_start(7, 4, s);
            wait_over(40, 16'hFFFF, 16, to);
            checks++;
            if (to || beat_mem[b0+1] !== exp_beat(1, 7, p)) begin
                errors++;
                $display("FAIL seq_ch7_pkt%0d: got %h want %h", p, beat_mem[b0+1], exp_beat(1, 7, p));
            end
        end
        b0 = beat_n;
        do_start(3, 4, s);
        wait_over(40, 16'hFFFF, 16, to);
        checks++;
        if (to || beat_mem[b0] !== exp_beat(0, 3, 0)) begin
            errors++;
            $display("FAIL seq_ch3_header: got %h want %h", beat_mem[b0], exp_beat(0, 3, 0));
        end
        checks++;
        if (beat_mem[b0+1] !== exp_beat(1, 3, 1)) begin
            errors++;
            $display("FAIL seq_ch3_first: got %h want %h", beat_mem[b0+1], exp_beat(1, 3, 1));
        end
    endtask

    task automatic test_skip();
        int s, b0, o0, r0, v0;
        bit to;
        apply_reset();
        b0 = beat_n; o0 = over_n; r0 = rdreq_cnt; v0 = valid_cnt;
        do_start(5, 3, s);
        wait_over(20, 16'hFFFF, 16, to);
        checks++;
        if (to || over_flg[o0] !== 2'b10) begin
            errors++;
            $display("FAIL skip_flags: got %b want 10 (skipped,ch_err)", over_flg[o0]);
        end
        checks++;
        if (over_cyc[o0] != s + 2) begin errors++; $display("FAIL skip_over_cycle: got %0d want 2", over_cyc[o0] - s); end
        checks++;
        if (beat_n - b0 != 0 || valid_cnt - v0 != 0 || rdreq_cnt - r0 != 0) begin
            errors++;
            $display("FAIL skip_no_output: got beats=%0d valid=%0d rdreq=%0d want 0/0/0",
                     beat_n - b0, valid_cnt - v0, rdreq_cnt - r0);
        end
        // Exactly PKT_LEN words, then the level drops after CHECK: packet still goes out.
        b0 = beat_n; o0 = over_n;
        do_start(5, 4, s);
        @(posedge clk); #1;
        bus.rdusedw = '0;
        wait_over(40, 16'hFFFF, 16, to);
        checks++;
        if (to || beat_n - b0 != 6) begin errors++; $display("FAIL exact_fill_beats: got %0d want 6", beat_n - b0); end
        checks++;
        if (beat_mem[b0+1] !== exp_beat(1, 5, 1)) begin
            errors++;
            $display("FAIL exact_fill_seq: got %h want %h", beat_mem[b0+1], exp_beat(1, 5, 1));
        end
        checks++;
        if (over_flg[o0] !== 2'b00) begin errors++; $display("FAIL exact_fill_flags: got %b want 00", over_flg[o0]); end
    endtask

    task automatic test_ch_range();
        int s, b0, o0, r0;
        bit to;
        apply_reset();
        b0 = beat_n; o0 = over_n; r0 = rdreq_cnt;
        do_start(30, 4, s);
        wait_over(20, 16'hFFFF, 16, to);
        checks++;
        if (to || over_flg[o0] !== 2'b01) begin
            errors++;
            $display("FAIL chrange_flags: got %b want 01 (skipped,ch_err)", over_flg[o0]);
        end
        checks++;
        if (over_cyc[o0] != s + 2) begin errors++; $display("FAIL chrange_over_cycle: got %0d want 2", over_cyc[o0] - s); end
        checks++;
        if (beat_n - b0 != 0 || rdreq_cnt - r0 != 0) begin
            errors++;
            $display("FAIL chrange_no_output: got beats=%0d rdreq=%0d want 0/0", beat_n - b0, rdreq_cnt - r0);
        end
        b0 = beat_n;
        do_start(29, 4, s);
        wait_over(40, 16'hFFFF, 16, to);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (to || beat_mem[b0+k] !== exp_beat(k, 29, 1)) begin
                errors++;
                $display("FAIL ch29_beat%0d: got %h want %h", k, beat_mem[b0+k], exp_beat(k, 29, 1));
            end
        end
    endtask

    task automatic test_backpressure();
        int s, b0, o0, r0, v0, sb0, rb0;
        bit to;
        apply_reset();
        b0 = beat_n; o0 = over_n; r0 = rdreq_cnt; v0 = valid_cnt; sb0 = stall_bad; rb0 = rdreq_bad;
        do_start(7, 4, s);
        wait_over(100, 16'h0A69, 12, to);
        checks++;
        if (to || beat_n - b0 != 6) begin errors++; $display("FAIL bp_beat_count: got %0d want 6", beat_n - b0); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (beat_mem[b0+k] !== exp_beat(k, 7, 1)) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h want %h", k, beat_mem[b0+k], exp_beat(k, 7, 1));
            end
        end
        checks++;
        if (stall_bad - sb0 != 0) begin errors++; $display("FAIL bp_stall_hold: got %0d changes want 0", stall_bad - sb0); end
        checks++;
        if (rdreq_bad - rb0 != 0) begin errors++; $display("FAIL bp_rdreq_no_load: got %0d want 0", rdreq_bad - rb0); end
        checks++;
        if (rdreq_cnt - r0 != 4) begin errors++; $display("FAIL bp_rdreq_count: got %0d want 4", rdreq_cnt - r0); end
        checks++;
        if (valid_cnt - v0 <= 6) begin errors++; $display("FAIL bp_valid_held: got %0d valid cycles want >6", valid_cnt - v0); end
        checks++;
        if (over_flg[o0] !== 2'b00) begin errors++; $display("FAIL bp_over_flags: got %b want 00", over_flg[o0]); end
    endtask

    task automatic test_reset_mid();
        int s, b0, o0;
        bit to;
        apply_reset();
        o0 = over_n;
        do_start(7, 4, s);
        repeat (5) @(posedge clk); #1;
        checks++;
        if (!(bus.data_valid === 1'b1 && bus.up_data === 64'h11)) begin
            errors++;
            $display("FAIL midrst_pre: got valid=%b data=%h want 1/11", bus.data_valid, bus.up_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.data_valid, bus.sop, bus.eop, bus.over, bus.skipped, bus.ch_err, bus.rdreq} !== 7'b0
            || bus.up_data !== 64'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got flags=%b data=%h want 0/0",
                     {bus.data_valid, bus.sop, bus.eop, bus.over, bus.skipped, bus.ch_err, bus.rdreq}, bus.up_data);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk); #1;
        checks++;
        if (over_n != o0 || bus.data_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: got overs=%0d valid=%b want 0/0", over_n - o0, bus.data_valid);
        end
        b0 = beat_n;
        do_start(7, 4, s);
        wait_over(40, 16'hFFFF, 16, to);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (to || beat_mem[b0+k] !== exp_beat(k, 7, 1)) begin
                errors++;
                $display("FAIL midrst_next_beat%0d: got %h want %h", k, beat_mem[b0+k], exp_beat(k, 7, 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_seq_count();
        test_skip();
        test_ch_range();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
